sdc_wr_blk_seq: RTL and testbench

Sequencer for multi-block SD card writes over the 1-bit DAT0 sender. Per block it fires the sender start strobe and generates system-memory word addresses, timed to the sender's word-capture strobes. After each block it waits out the card's write-busy, enforces an inter-block gap, and repeats until the requested block count is done or an error occurs. Sits between the SD command/host FSM (start/abort/status) and the sender plus system-memory RAM read port.

---
 rtl/sdc_pkg.sv | 21 ++
 rtl/sdc_busy_tmo.sv | 33 +++
 rtl/sdc_wr_blk_seq.sv | 162 ++++++++++++++++
 tb/tb_sdc_wr_blk_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdc_pkg.sv
// Shared types and timing constants for the SD write-path sequencers.
package sdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_XFER,
    ST_SETTLE,
    ST_WAIT_BUSY,
    ST_GAP,
    ST_FIN
  } wr_seq_state_t;

  localparam int unsigned WRDS_PER_BLK_DFLT = 64;
  localparam int unsigned SETTLE_CLKS_DFLT  = 4;
  localparam int unsigned GAP_CLKS_DFLT     = 8;
  localparam int unsigned GAP_CLKS_MIN      = 2;
  localparam int unsigned BUSY_TMO_W        = 24;

endpackage

// File: rtl/sdc_busy_tmo.sv
// Loadable down-counter; expire pulses on the last cycle of a loaded interval.
module sdc_busy_tmo #(
  parameter int unsigned W = 24
) (
  input  logic         sd_clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic         running;

  // A load of N yields exactly N cycles of running, expire on the Nth.
  assign expire = running && (cnt == W'(1));

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= load_val;
      running <= (load_val != '0);
    end else if (clr || expire) begin
      running <= 1'b0;
    end else if (running) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/sdc_wr_blk_seq.sv
// Multi-block SD write sequencer: per-block sender start, RAM address stepping,
// busy wait with timeout, inter-block gap and abort handling.
module sdc_wr_blk_seq
  import sdc_pkg::*;
#(
  parameter int unsigned            AW           = 16,
  parameter int unsigned            WRDS_PER_BLK = WRDS_PER_BLK_DFLT,
  parameter int unsigned            GAP_CLKS     = GAP_CLKS_DFLT,
  parameter logic [BUSY_TMO_W-1:0]  BUSY_TMO     = 24'hFFFFFF,
  parameter int unsigned            SETTLE_CLKS  = SETTLE_CLKS_DFLT
) (
  input  logic          sd_clk,
  input  logic          reset,
  input  logic          start_strb,
  input  logic [15:0]   blk_cnt,
  input  logic [AW-1:0] base_addr,
  input  logic          abort_strb,
  output logic          strt_snd_data_strb,
  input  logic          new_dat_strb,
  input  logic          dat_tf_done,
  input  logic          wr_busy,
  output logic [AW-1:0] sm_rd_addr,
  output logic          sm_rd_en,
  output logic          busy,
  output logic [15:0]   blks_done,
  output logic          done_strb,
  output logic          err_tmo
);

  localparam int unsigned IC_W = $clog2(WRDS_PER_BLK + 1);
  localparam logic [IC_W-1:0] INC_MAX = IC_W'(WRDS_PER_BLK);
  localparam logic [BUSY_TMO_W-1:0] SETTLE_LD =
    BUSY_TMO_W'((SETTLE_CLKS == 0) ? 1 : SETTLE_CLKS);
  localparam logic [BUSY_TMO_W-1:0] GAP_LD =
    BUSY_TMO_W'((GAP_CLKS < GAP_CLKS_MIN) ? GAP_CLKS_MIN : GAP_CLKS);

  wr_seq_state_t st, nxt;

  logic [15:0]           cnt_lat;
  logic                  abort_pend;
  logic                  zero_done;
  logic [1:0]            strt_dly;
  logic [IC_W-1:0]       inc_cnt;
  logic                  tmr_ld;
  logic                  tmr_clr;
  logic [BUSY_TMO_W-1:0] tmr_val;
  logic                  tmr_exp;
  logic                  blk_last;

  sdc_busy_tmo #(.W(BUSY_TMO_W)) u_tmr (
    .sd_clk   (sd_clk),
    .reset    (reset),
    .load     (tmr_ld),
    .clr      (tmr_clr),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  assign strt_snd_data_strb = (st == ST_START);
  assign sm_rd_en           = (st inside {ST_LOAD, ST_START, ST_XFER});
  assign busy               = (st != ST_IDLE);
  assign done_strb          = (st == ST_FIN) || zero_done;
  assign blk_last           = abort_strb || abort_pend || (blks_done == cnt_lat);

  always_ff @(posedge sd_clk) begin
    if (reset) st <= ST_IDLE;
    else       st <= nxt;
  end

  always_comb begin
    nxt     = st;
    tmr_ld  = 1'b0;
    tmr_clr = 1'b0;
    tmr_val = '0;
    unique case (st)
      ST_IDLE:   if (start_strb && (blk_cnt != '0)) nxt = ST_LOAD;
      ST_LOAD:   nxt = abort_strb ? ST_FIN : ST_START;
      ST_START:  nxt = abort_strb ? ST_FIN : ST_XFER;
      ST_XFER: begin
        if (dat_tf_done) begin
          nxt     = ST_SETTLE;
          tmr_ld  = 1'b1;
          tmr_val = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (tmr_exp) begin
          nxt     = ST_WAIT_BUSY;
          tmr_ld  = 1'b1;
          tmr_val = BUSY_TMO;
        end
      end
      ST_WAIT_BUSY: begin
        // Busy release wins over a same-cycle timeout.
        if (!wr_busy) begin
          tmr_clr = 1'b1;
          if (blk_last) begin
            nxt = ST_FIN;
          end else begin
            nxt     = ST_GAP;
            tmr_ld  = 1'b1;
            tmr_val = GAP_LD;
          end
        end else if (tmr_exp) begin
          nxt = ST_FIN;
        end
      end
      ST_GAP: begin
        if (abort_strb) begin
          nxt     = ST_FIN;
          tmr_clr = 1'b1;
        end else if (tmr_exp) begin
          nxt = ST_LOAD;
        end
      end
      ST_FIN:    nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (reset) begin
      cnt_lat    <= '0;
      blks_done  <= '0;
      err_tmo    <= 1'b0;
      sm_rd_addr <= '0;
      abort_pend <= 1'b0;
      zero_done  <= 1'b0;
      strt_dly   <= '0;
      inc_cnt    <= '0;
    end else begin
      zero_done <= (st == ST_IDLE) && start_strb && (blk_cnt == '0);
      strt_dly  <= {strt_dly[0], strt_snd_data_strb};

      if ((st == ST_IDLE) && start_strb) begin
        cnt_lat    <= blk_cnt;
        blks_done  <= '0;
        err_tmo    <= 1'b0;
        sm_rd_addr <= base_addr;
        abort_pend <= 1'b0;
      end

      // Word 0 is captured two cycles after our own start strobe; later words on new_dat_strb.
      if (st == ST_START) begin
        inc_cnt <= '0;
      end else if ((st == ST_XFER) && (strt_dly[1] || new_dat_strb) && (inc_cnt < INC_MAX)) begin
        sm_rd_addr <= sm_rd_addr + AW'(1);
        inc_cnt    <= inc_cnt + IC_W'(1);
      end

      if ((st == ST_XFER) && dat_tf_done)
        blks_done <= blks_done + 16'd1;

      if (abort_strb && (st inside {ST_XFER, ST_SETTLE, ST_WAIT_BUSY}))
        abort_pend <= 1'b1;

      if ((st == ST_WAIT_BUSY) && wr_busy && tmr_exp)
        err_tmo <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdc_wr_blk_seq.sv
// Scoreboard bench for sdc_wr_blk_seq with a behavioural DAT0 sender model.
module tb_sdc_wr_blk_seq;

  localparam int unsigned WRDS = 64;
  localparam int unsigned GAP  = 8;

  logic        sd_clk;
  logic        reset;
  logic        start_strb;
  logic [15:0] blk_cnt;
  logic [15:0] base_addr;
  logic        abort_strb;
  logic        strt_snd_data_strb;
  logic        new_dat_strb;
  logic        dat_tf_done;
  logic        wr_busy;
  logic [15:0] sm_rd_addr;
  logic        sm_rd_en;
  logic        busy;
  logic [15:0] blks_done;
  logic        done_strb;
  logic        err_tmo;

  sdc_wr_blk_seq #(
    .AW           (16),
    .WRDS_PER_BLK (WRDS),
    .GAP_CLKS     (GAP),
    .BUSY_TMO     (24'd1000),
    .SETTLE_CLKS  (4)
  ) dut (
    .sd_clk             (sd_clk),
    .reset              (reset),
    .start_strb         (start_strb),
    .blk_cnt            (blk_cnt),
    .base_addr          (base_addr),
    .abort_strb         (abort_strb),
    .strt_snd_data_strb (strt_snd_data_strb),
    .new_dat_strb       (new_dat_strb),
    .dat_tf_done        (dat_tf_done),
    .wr_busy            (wr_busy),
    .sm_rd_addr         (sm_rd_addr),
    .sm_rd_en           (sm_rd_en),
    .busy               (busy),
    .blks_done          (blks_done),
    .done_strb          (done_strb),
    .err_tmo            (err_tmo)
  );

  initial begin
    sd_clk = 1'b0;
    forever #5 sd_clk = ~sd_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] exp_start_q[$];
  logic [16:0] exp_done_q[$];   // {blks_done, err_tmo}

  int unsigned snd_spacing   = 4;
  int unsigned snd_extra     = 0;
  int unsigned snd_busy_clks = 100;
  bit          snd_active    = 1'b0;
  bit          snd_in_busy   = 1'b0;
  int          n_starts      = 0;
  int          seq_blk       = 0;
  int          last_rel_cyc  = 0;
  int          dat_done_cyc  = 0;
  int          done_cnt      = 0;
  int          done_cyc      = 0;
  bit          busy_seen     = 1'b0;
  logic        prev_done     = 1'b0;

  always @(posedge sd_clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Sender model: answers each start strobe with a full block, then holds busy.
  initial begin : sender
    logic [15:0] blk_exp;
    logic [15:0] exp_a;
    new_dat_strb = 1'b0;
    dat_tf_done  = 1'b0;
    wr_busy      = 1'b0;
    forever begin
      @(negedge sd_clk);
      if (strt_snd_data_strb === 1'b1 && reset === 1'b0) begin
        snd_active = 1'b1;
        n_starts++;
        check_val("start_expected", 32'(exp_start_q.size() != 0), 32'd1);
        blk_exp = (exp_start_q.size() != 0) ? exp_start_q.pop_front() : 16'h0;
        check_val("blk_start_addr", 32'(sm_rd_addr), 32'(blk_exp));
        if (seq_blk > 0)
          check_val("gap_min", 32'((cyc - last_rel_cyc) >= int'(GAP)), 32'd1);
        seq_blk++;
        @(negedge sd_clk);
        check_val("strt_width", 32'(strt_snd_data_strb), 32'd0);
        @(negedge sd_clk);
        check_val("word0_addr", 32'(sm_rd_addr), 32'(blk_exp));
        check_val("rd_en_xfer", 32'(sm_rd_en), 32'd1);
        for (int k = 1; k <= int'(WRDS - 1 + snd_extra); k++) begin
          repeat (snd_spacing - 1) @(negedge sd_clk);
          new_dat_strb = 1'b1;
          exp_a = (k < int'(WRDS)) ? blk_exp + 16'(k) : blk_exp + 16'(WRDS);
          check_val("word_addr", 32'(sm_rd_addr), 32'(exp_a));
          @(negedge sd_clk);
          new_dat_strb = 1'b0;
        end
        repeat (2) @(negedge sd_clk);
        exp_a = blk_exp + 16'(WRDS);
        check_val("blk_end_addr", 32'(sm_rd_addr), 32'(exp_a));
        dat_tf_done  = 1'b1;
        dat_done_cyc = cyc;
        @(negedge sd_clk);
        dat_tf_done = 1'b0;
        wr_busy     = 1'b1;
        snd_in_busy = 1'b1;
        repeat (snd_busy_clks) @(negedge sd_clk);
        wr_busy      = 1'b0;
        last_rel_cyc = cyc;
        snd_in_busy  = 1'b0;
        snd_active   = 1'b0;
      end
    end
  end

  always @(negedge sd_clk) begin : done_mon
    logic [16:0] rec;
    if (busy === 1'b1) busy_seen = 1'b1;
    if (done_strb === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check_val("done_width", 32'(prev_done), 32'd0);
      check_val("done_expected", 32'(exp_done_q.size()), 32'd1);
      if (exp_done_q.size() != 0) begin
        rec = exp_done_q.pop_front();
        check_val("done_blks", 32'(blks_done), 32'(rec[16:1]));
        check_val("done_err", 32'(err_tmo), 32'(rec[0]));
      end
    end
    prev_done = done_strb;
  end

  task automatic do_start(input logic [15:0] cnt, input logic [15:0] base);
    @(negedge sd_clk);
    seq_blk    = 0;
    blk_cnt    = cnt;
    base_addr  = base;
    start_strb = 1'b1;
    @(negedge sd_clk);
    start_strb = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int tgt, input int max_cyc);
    int i = 0;
    while (done_cnt < tgt && i < max_cyc) begin
      @(negedge sd_clk);
      i++;
    end
    check_val(tag, 32'(done_cnt >= tgt), 32'd1);
  endtask

  task automatic wait_snd_idle(input int max_cyc);
    int i = 0;
    while ((snd_active || snd_in_busy) && i < max_cyc) begin
      @(negedge sd_clk);
      i++;
    end
    check_val("sender_idle", 32'(snd_active || snd_in_busy), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0;
    int d0;
    reset      = 1'b1;
    start_strb = 1'b0;
    abort_strb = 1'b0;
    blk_cnt    = '0;
    base_addr  = '0;
    repeat (3) @(negedge sd_clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_strt", 32'(strt_snd_data_strb), 32'd0);
    check_val("rst_rd_en", 32'(sm_rd_en), 32'd0);
    check_val("rst_addr", 32'(sm_rd_addr), 32'd0);
    check_val("rst_blks", 32'(blks_done), 32'd0);
    check_val("rst_done", 32'(done_strb), 32'd0);
    check_val("rst_err", 32'(err_tmo), 32'd0);
    reset = 1'b0;

    // Single block, slow sender, extra strobes beyond the block must not move the address.
    snd_spacing = 62; snd_extra = 2;
    exp_start_q.push_back(16'h0100);
    exp_done_q.push_back({16'd1, 1'b0});
    s0 = n_starts; d0 = done_cnt;
    do_start(16'd1, 16'h0100);
    wait_done("t1_done", d0 + 1, 6000);
    check_val("t1_starts", 32'(n_starts - s0), 32'd1);
    wait_snd_idle(300);

    // Three blocks wrapping past 0xFFFF; a start while busy is ignored.
    snd_spacing = 4; snd_extra = 0;
    exp_start_q.push_back(16'hFFA0);
    exp_start_q.push_back(16'hFFE0);
    exp_start_q.push_back(16'h0020);
    exp_done_q.push_back({16'd3, 1'b0});
    s0 = n_starts; d0 = done_cnt;
    do_start(16'd3, 16'hFFA0);
    for (int i = 0; i < 50 && !snd_active; i++) @(negedge sd_clk);
    blk_cnt = 16'd1; base_addr = 16'h5555; start_strb = 1'b1;
    @(negedge sd_clk);
    start_strb = 1'b0;
    wait_done("t2_done", d0 + 1, 3000);
    check_val("t2_starts", 32'(n_starts - s0), 32'd3);
    check_val("t2_final_addr", 32'(sm_rd_addr), 32'h0060);
    wait_snd_idle(300);

    // Busy timeout on block 1 of 2.
    snd_busy_clks = 1500;
    exp_start_q.push_back(16'h3000);
    exp_done_q.push_back({16'd1, 1'b1});
    s0 = n_starts; d0 = done_cnt;
    do_start(16'd2, 16'h3000);
    wait_done("t3_done", d0 + 1, 2500);
    check_val("t3_tmo_latency", 32'((done_cyc - dat_done_cyc) >= 1000 && (done_cyc - dat_done_cyc) <= 1010), 32'd1);
    check_val("t3_err_sticky", 32'(err_tmo), 32'd1);
    wait_snd_idle(2000);
    check_val("t3_starts", 32'(n_starts - s0), 32'd1);
    snd_busy_clks = 100;

    // Zero block count: done next cycle, never busy, clears the sticky error.
    busy_seen = 1'b0;
    exp_done_q.push_back({16'd0, 1'b0});
    s0 = n_starts; d0 = done_cnt;
    do_start(16'd0, 16'h7000);
    check_val("t5_done_next", 32'(done_strb), 32'd1);
    wait_done("t5_done", d0 + 1, 5);
    repeat (5) @(negedge sd_clk);
    check_val("t5_busy_never", 32'(busy_seen), 32'd0);
    check_val("t5_starts", 32'(n_starts - s0), 32'd0);
    check_val("t5_err_clr", 32'(err_tmo), 32'd0);

    // Abort mid-transfer of block 1 of 4.
    exp_start_q.push_back(16'h2000);
    exp_done_q.push_back({16'd1, 1'b0});
    s0 = n_starts; d0 = done_cnt;
    do_start(16'd4, 16'h2000);
    for (int i = 0; i < 50 && !snd_active; i++) @(negedge sd_clk);
    repeat (20) @(negedge sd_clk);
    abort_strb = 1'b1;
    @(negedge sd_clk);
    abort_strb = 1'b0;
    wait_done("t4_done", d0 + 1, 1000);
    repeat (50) @(negedge sd_clk);
    check_val("t4_starts", 32'(n_starts - s0), 32'd1);
    wait_snd_idle(300);

    // Reset while waiting on card busy, then a clean restart.
    exp_start_q.push_back(16'h4000);
    d0 = done_cnt;
    do_start(16'd1, 16'h4000);
    for (int i = 0; i < 600 && !snd_in_busy; i++) @(negedge sd_clk);
    check_val("t6_in_busy", 32'(snd_in_busy), 32'd1);
    repeat (20) @(negedge sd_clk);
    check_val("t6_pre_blks", 32'(blks_done), 32'd1);
    reset = 1'b1;
    @(negedge sd_clk);
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_blks", 32'(blks_done), 32'd0);
    check_val("t6_addr", 32'(sm_rd_addr), 32'd0);
    check_val("t6_err", 32'(err_tmo), 32'd0);
    reset = 1'b0;
    wait_snd_idle(300);
    check_val("t6_no_done", 32'(done_cnt - d0), 32'd0);
    exp_start_q.push_back(16'hABC0);
    exp_done_q.push_back({16'd1, 1'b0});
    s0 = n_starts; d0 = done_cnt;
    do_start(16'd1, 16'hABC0);
    wait_done("t6_restart_done", d0 + 1, 1000);
    check_val("t6_restart_starts", 32'(n_starts - s0), 32'd1);
    wait_snd_idle(300);

    check_val("start_q_empty", 32'(exp_start_q.size()), 32'd0);
    check_val("done_q_empty", 32'(exp_done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
